// File: rtl/regfile_param.sv
// Parametrised register file: 2 combinational read ports, 1 write port, $v0 tap, post-reset clear sequencer (optional bypass: REGFILE_BYPASS_EN).
// Latency: reads 0 cycles; writes visible after the write edge; clear takes NUM_REGS enabled cycles.
// Backpressure: none; writes during the clear sequence are dropped and flagged on sticky write_dropped.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int V0_IDX   = 2,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              r_clk,
    input  logic              reset,
    input  logic              r_clk_enable,
    input  logic              write_control,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] register_v0,
    output logic              busy,
    output logic              write_dropped
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] V0_ADDR  = ADDR_W'(V0_IDX);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] registers [NUM_REGS];

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;

    assign busy = (state == ST_CLEAR);

    always_ff @(posedge r_clk) begin
        if (reset) begin
            state         <= ST_CLEAR;
            clr_idx       <= '0;
            write_dropped <= 1'b0;
        end else if (r_clk_enable && state == ST_CLEAR) begin
            // clr_idx parks on the last index rather than wrapping
            if (clr_idx == LAST_IDX) begin
                state <= ST_READY;
            end else begin
                clr_idx <= clr_idx + ADDR_W'(1);
            end
            if (write_control) begin
                write_dropped <= 1'b1;
            end
        end
    end

    // Single array write port shared by the clear sequencer and writeback
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = write_reg;
        arr_wdata = write_data;
        if (!reset && r_clk_enable) begin
            if (state == ST_CLEAR) begin
                arr_we    = 1'b1;
                arr_waddr = clr_idx;
                arr_wdata = '0;
            end else if (write_control && write_reg != '0) begin
                arr_we = 1'b1;
            end
        end
    end

    always_ff @(posedge r_clk) begin
        if (arr_we) begin
            registers[arr_waddr] <= arr_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = registers[addr];
`ifdef REGFILE_BYPASS_EN
        if (r_clk_enable && write_control && write_reg != '0 && write_reg == addr) begin
            val = write_data;
        end
`endif
        if (busy || addr == '0) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        read_data1  = read_port(read_reg1);
        read_data2  = read_port(read_reg2);
        register_v0 = read_port(V0_ADDR);
    end

endmodule
